layer3_out_serializer: RTL and testbench
========================================

// Module: layer3_out_serializer
// PURPOSE
//  Read-side consumer of the 15-node layer-3 output bus. On a start pulse it waits out the node
//  pipeline latency, snapshots all N_NODES 24-bit signed fixed-point results, then streams them
//  one word per accepted beat over a valid/ready interface (index + last tag) toward layer 4 /
//  the host readout. Decouples the wide parallel layer output from narrow downstream logic.
// PARAMETERS
//  WIDTH    24  bits per node value (signed two's complement fixed-point)
//  N_NODES  15  number of node outputs captured per inference
//  LATENCY  4   clk cycles from start to valid node outputs (node pipeline depth), >=1
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               synchronous, active-high reset
//  start      in   1               one-cycle pulse: layer-3 inputs applied this cycle
//  nodes_in   in   N_NODES*WIDTH   node outputs; N1x at [WIDTH-1:0], N15x at top slice
//  busy       out  1               high from accepted start until done pulse (inclusive)
//  out_data   out  WIDTH           current streamed word
//  out_index  out  4               node index 0..N_NODES-1 (0 = N1x)
//  out_valid  out  1               out_data/out_index/out_last valid
//  out_last   out  1               high with final word (index N_NODES-1)
//  out_ready  in   1               downstream accepts when out_valid&&out_ready
//  done       out  1               one-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE; busy,out_valid,out_last,done=0; out_data,out_index=0; snapshot
//    cleared. Reset mid-operation aborts immediately; no done pulse; partial stream discarded.
//  - IDLE: start=1 -> WAIT, wait counter loaded LATENCY-1, busy=1 next cycle.
//  - WAIT: counter decrements each cycle; at 0 -> CAPTURE snapshot of nodes_in on that edge, go STREAM
//    with out_valid=1, out_index=0, out_data=N1x slice. First word valid LATENCY+1 cycles after start.
//  - STREAM: outputs held stable while out_valid&&!out_ready. On accept with index<N_NODES-1,
//    index increments, next word presented next cycle (full throughput 1 word/cycle). out_last=1
//    exactly when index==N_NODES-1. Accept of last word -> DONE.
//  - DONE: out_valid=0, done=1 for one cycle, busy=1 this cycle; next cycle IDLE, busy=0.
//  - start while busy (WAIT/STREAM/DONE) is ignored; no queuing. start in IDLE same cycle as DONE
//    exit is not possible (DONE precedes IDLE); earliest restart is cycle after done.
//  - nodes_in changes after capture do not affect stream (snapshot only).
//  - out_index width fixed 4 bits; N_NODES must be <=16.
//  - No arithmetic on data in base configuration; words pass bit-exact.
// CONFIGURATION
//  LAYER3_ARGMAX_EN defined: adds outputs argmax_idx [3:0] and argmax_val [WIDTH-1:0]; during STREAM
//   each accepted word compared signed against running max (index 0 initialises); ties keep lower
//   index; both registered, valid when done pulses, held until next start accepted; reset to 0.
//  Not defined: ports and comparator logic absent; behaviour otherwise identical.
// TESTING
//  1 reset, start at cycle 0, nodes_in slice k = k+1, out_ready=1 -> out_valid at cycle 5, indices
//    0..14 data 1..15 on consecutive cycles, out_last with index 14, done one cycle later.
//  2 out_ready toggling 1,0,0,1... -> each word held stable while stalled, no skip/duplicate, 15 beats.
//  3 change nodes_in to all 0xFFFFFF right after capture -> streamed data still 1..15.
//  4 start pulses during WAIT and STREAM -> ignored, exactly one 15-word stream, one done.
//  5 reset asserted at 7th beat -> next cycle out_valid=0, busy=0, done=0; new start gives full stream.
//  6 (LAYER3_ARGMAX_EN) slices: N4x=0x7FFFFF, N9x=0x7FFFFF, rest 0x800000 -> argmax_idx=3,
//    argmax_val=0x7FFFFF at done; all slices 0xFFFFFE -> argmax_idx=0.

Source files
------------

// File: rtl/layer3_out_serializer_if.sv
// ---------------------------------------------------------------------------
// layer3_out_serializer_if
//   Word-stream bus from the layer-3 output serializer toward layer 4 / host
//   readout. One word is transferred on every cycle where out_valid and
//   out_ready are both high.
//
//   Signals
//     out_data   WIDTH  streamed node value (signed fixed-point, bit-exact)
//     out_index  4      node index 0..N_NODES-1 (0 = N1x)
//     out_valid  1      out_data/out_index/out_last are valid
//     out_last   1      final word of the stream
//     out_ready  1      consumer accepts the current word
//
//   Modports
//     master  serializer side (drives data/index/valid/last, samples ready)
//     slave   consumer side
// ---------------------------------------------------------------------------
interface layer3_out_serializer_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_index;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/layer3_out_serializer.sv
// ---------------------------------------------------------------------------
// layer3_out_serializer
//   Read-side consumer of the layer-3 node output bus. A start pulse launches
//   a wait of LATENCY cycles for the node pipeline to settle, after which all
//   N_NODES results are captured into a snapshot register and streamed one
//   word per accepted beat over a valid/ready bus (index + last tag).
//   Changes on nodes_in after the capture edge do not affect the stream.
//
//   Parameters
//     WIDTH    bits per node value (signed two's complement)
//     N_NODES  node outputs captured per inference (<= 16, out_index is 4 bits)
//     LATENCY  cycles from start to valid node outputs (>= 1)
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   synchronous active-high reset; aborts any stream, no done
//     start     in   one-cycle launch pulse; ignored unless idle
//     nodes_in  in   N_NODES*WIDTH node outputs, N1x in the lowest slice
//     busy      out  high from the cycle after an accepted start through done
//     done      out  one-cycle pulse after the last word is accepted
//     out_if    master side of layer3_out_serializer_if (data/index/valid/
//               last out, ready in)
//
//   Optional build macro LAYER3_ARGMAX_EN
//     Adds argmax_idx[3:0] / argmax_val[WIDTH-1:0]: a running signed maximum
//     over the accepted words (index 0 initialises, ties keep the lower
//     index). Final when done pulses and held until overwritten by the first
//     accepted word of the next stream. Both reset to 0.
//
//   Timing (LATENCY=4, start sampled at the end of cycle 0)
//     cycles 1..4  WAIT, busy=1
//     end cycle 4  snapshot captured
//     cycle 5      first word valid (index 0)
// ---------------------------------------------------------------------------
module layer3_out_serializer #(
  parameter int WIDTH   = 24,
  parameter int N_NODES = 15,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [N_NODES*WIDTH-1:0]   nodes_in,
  output logic                       busy,
  output logic                       done,
`ifdef LAYER3_ARGMAX_EN
  output logic [3:0]                 argmax_idx,
  output logic [WIDTH-1:0]           argmax_val,
`endif
  layer3_out_serializer_if.master    out_if
);

  // Counter only needs to hold LATENCY-1.
  localparam int         CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [3:0] LAST_IDX = 4'(N_NODES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_index;
  logic [3:0]       w_index_nxt;
  logic             w_capture;
  logic             w_accept;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_snap [N_NODES];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_index_nxt = r_index;
    w_capture   = 1'b0;
    w_accept    = (r_state == S_STREAM) && out_if.out_ready;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          // Node outputs are valid on this edge: snapshot and present word 0.
          w_capture   = 1'b1;
          w_index_nxt = '0;
          w_state_nxt = S_STREAM;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_STREAM: begin
        if (w_accept) begin
          if (r_index == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + 1'b1;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_index_nxt = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counter, index and snapshot registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_index <= '0;
      for (int unsigned k = 0; k < N_NODES; k++) begin
        r_snap[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_index <= w_index_nxt;
      if (w_capture) begin
        for (int unsigned k = 0; k < N_NODES; k++) begin
          r_snap[k] <= nodes_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all derived from registered state, so they stay stable for the
  // whole cycle while the consumer stalls.
  // -------------------------------------------------------------------------
  assign w_word = r_snap[r_index];

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign out_if.out_valid = (r_state == S_STREAM);
  assign out_if.out_last  = (r_state == S_STREAM) && (r_index == LAST_IDX);
  assign out_if.out_index = r_index;
  assign out_if.out_data  = (r_state == S_STREAM) ? w_word : '0;

`ifdef LAYER3_ARGMAX_EN
  // -------------------------------------------------------------------------
  // Running signed maximum over accepted words
  // -------------------------------------------------------------------------
  logic [3:0]       r_amax_idx;
  logic [WIDTH-1:0] r_amax_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_amax_idx <= '0;
      r_amax_val <= '0;
    end else if (w_accept) begin
      // Strict '>' keeps the earlier (lower) index on ties.
      if ((r_index == '0) || ($signed(w_word) > $signed(r_amax_val))) begin
        r_amax_idx <= r_index;
        r_amax_val <= w_word;
      end
    end
  end

  assign argmax_idx = r_amax_idx;
  assign argmax_val = r_amax_val;
`endif

endmodule

// File: tb/tb_layer3_out_serializer.sv
module tb_layer3_out_serializer;

  localparam int WIDTH   = 24;
  localparam int N_NODES = 15;
  localparam int LATENCY = 4;
  localparam int NW      = N_NODES * WIDTH;
  localparam int BUDGET  = 600;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NW-1:0] nodes_in;
  logic          busy;
  logic          done;
`ifdef LAYER3_ARGMAX_EN
  logic [3:0]       argmax_idx;
  logic [WIDTH-1:0] argmax_val;
`endif

  int n_checks = 0;
  int n_errors = 0;

  layer3_out_serializer_if #(.WIDTH(WIDTH)) bus ();

  layer3_out_serializer #(
    .WIDTH   (WIDTH),
    .N_NODES (N_NODES),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nodes_in   (nodes_in),
    .busy       (busy),
    .done       (done),
`ifdef LAYER3_ARGMAX_EN
    .argmax_idx (argmax_idx),
    .argmax_val (argmax_val),
`endif
    .out_if     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] mk_inc();
    logic [NW-1:0] v;
    for (int k = 0; k < N_NODES; k++) v[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    return v;
  endfunction

  function automatic logic [NW-1:0] mk_fill(input logic [WIDTH-1:0] val);
    logic [NW-1:0] v;
    for (int k = 0; k < N_NODES; k++) v[k*WIDTH +: WIDTH] = val;
    return v;
  endfunction

  function automatic logic [NW-1:0] mk_rand();
    logic [NW-1:0] v;
    for (int k = 0; k < N_NODES; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*WIDTH +: WIDTH] = 24'h800000;
        1:       v[k*WIDTH +: WIDTH] = 24'h7FFFFF;
        default: v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      endcase
    end
    return v;
  endfunction

  // Reference model: the stream is the list of captured node values in index
  // order; the first word appears LATENCY+1 cycles after start, each cycle
  // with ready pops one word, done follows the last pop by one cycle.
  // mode 0: ready always 1; mode 1: ready 1,0,0,... ; mode 2: random ready,
  // random spurious start, random nodes_in after capture.
  task automatic run_stream(input int mode, input logic [NW-1:0] nodes);
    logic [WIDTH-1:0] q[$];
    logic [3:0]       e_ai;
    logic [WIDTH-1:0] e_av;
    int               cyc;
    bit               done_seen;

    for (int k = 0; k < N_NODES; k++) q.push_back(nodes[k*WIDTH +: WIDTH]);
    e_ai = '0;
    e_av = q[0];
    for (int k = 1; k < N_NODES; k++) begin
      if ($signed(q[k]) > $signed(e_av)) begin
        e_ai = 4'(k);
        e_av = q[k];
      end
    end

    nodes_in      = nodes;
    bus.out_ready = 1'b1;
    start         = 1'b1;
    chk("idle_before_start", {31'b0, busy}, 32'd0);
    step();
    start     = 1'b0;
    cyc       = 1;
    done_seen = 1'b0;

    while (!done_seen && cyc < BUDGET) begin
      if (cyc > LATENCY) begin
        case (mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = (((cyc - LATENCY - 1) % 3) == 0);
          default: bus.out_ready = $urandom_range(0, 1) != 0;
        endcase
        if (mode == 2) nodes_in = mk_rand();
      end
      if (mode == 2) start = ($urandom_range(0, 3) == 0);

      if (cyc <= LATENCY) begin
        chk("wait_busy", {31'b0, busy}, 32'd1);
        chk("wait_valid", {31'b0, bus.out_valid}, 32'd0);
      end else if (q.size() != 0) begin
        chk("stream_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stream_index", {28'b0, bus.out_index}, 32'(N_NODES - q.size()));
        chk("stream_data", {8'b0, bus.out_data}, {8'b0, q[0]});
        chk("stream_last", {31'b0, bus.out_last}, {31'b0, q.size() == 1});
        chk("stream_done", {31'b0, done}, 32'd0);
        chk("stream_busy", {31'b0, busy}, 32'd1);
        if (bus.out_ready) void'(q.pop_front());
      end else begin
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("done_busy", {31'b0, busy}, 32'd1);
`ifdef LAYER3_ARGMAX_EN
        chk("argmax_idx", {28'b0, argmax_idx}, {28'b0, e_ai});
        chk("argmax_val", {8'b0, argmax_val}, {8'b0, e_av});
`endif
        done_seen = 1'b1;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (!done_seen) chk("stream_timeout", 32'd0, 32'd1);
    chk("after_done_busy", {31'b0, busy}, 32'd0);
    chk("after_done_done", {31'b0, done}, 32'd0);
    chk("after_done_valid", {31'b0, bus.out_valid}, 32'd0);
  endtask

  typedef struct {
    logic             start;
    logic             ready;
    logic             corrupt;
    logic             e_busy;
    logic             e_valid;
    logic             e_last;
    logic             e_done;
    logic [3:0]       e_idx;
    logic [WIDTH-1:0] e_data;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // Cycle-exact table: start at cycle 0 plus ignored starts in WAIT (2),
    // STREAM (8) and DONE (20); nodes_in overwritten right after capture.
    for (int n = 0; n < 22; n++) begin
      tbl[n].start   = (n == 0) || (n == 2) || (n == 8) || (n == 20);
      tbl[n].ready   = 1'b1;
      tbl[n].corrupt = (n >= 5);
      tbl[n].e_busy  = (n >= 1) && (n <= 20);
      tbl[n].e_valid = (n >= 5) && (n <= 19);
      tbl[n].e_last  = (n == 19);
      tbl[n].e_done  = (n == 20);
      tbl[n].e_idx   = tbl[n].e_valid ? 4'(n - 5) : 4'd0;
      tbl[n].e_data  = tbl[n].e_valid ? WIDTH'(n - 4) : '0;
    end

    reset         = 1'b1;
    start         = 1'b0;
    nodes_in      = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_last", {31'b0, bus.out_last}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_index", {28'b0, bus.out_index}, 32'd0);
    chk("reset_data", {8'b0, bus.out_data}, 32'd0);
`ifdef LAYER3_ARGMAX_EN
    chk("reset_argmax_idx", {28'b0, argmax_idx}, 32'd0);
    chk("reset_argmax_val", {8'b0, argmax_val}, 32'd0);
`endif
    reset = 1'b0;
    step();

    for (int n = 0; n < 22; n++) begin
      start         = tbl[n].start;
      bus.out_ready = tbl[n].ready;
      nodes_in      = tbl[n].corrupt ? mk_fill(24'hFFFFFF) : mk_inc();
      chk("tbl_busy", {31'b0, busy}, {31'b0, tbl[n].e_busy});
      chk("tbl_valid", {31'b0, bus.out_valid}, {31'b0, tbl[n].e_valid});
      chk("tbl_last", {31'b0, bus.out_last}, {31'b0, tbl[n].e_last});
      chk("tbl_done", {31'b0, done}, {31'b0, tbl[n].e_done});
      if (tbl[n].e_valid) begin
        chk("tbl_index", {28'b0, bus.out_index}, {28'b0, tbl[n].e_idx});
        chk("tbl_data", {8'b0, bus.out_data}, {8'b0, tbl[n].e_data});
      end
      step();
    end
    start = 1'b0;

    // Stalling consumer, ready pattern 1,0,0,...
    run_stream(1, mk_inc());

    // Reset on the 7th beat (index 6, cycle 11 after start).
    nodes_in      = mk_inc();
    bus.out_ready = 1'b1;
    start         = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 11; c++) step();
    chk("pre_reset_index", {28'b0, bus.out_index}, 32'd6);
    chk("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("abort_no_done", {31'b0, done}, 32'd0);
      chk("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
    end
    run_stream(0, mk_inc());

    // Randomized streams against the reference model.
    for (int r = 0; r < 8; r++) run_stream(2, mk_rand());

`ifdef LAYER3_ARGMAX_EN
    begin
      logic [NW-1:0] v;
      v = mk_fill(24'h800000);
      v[3*WIDTH +: WIDTH] = 24'h7FFFFF;
      v[8*WIDTH +: WIDTH] = 24'h7FFFFF;
      run_stream(0, v);
      chk("argmax_hold_idx", {28'b0, argmax_idx}, 32'd3);
      chk("argmax_hold_val", {8'b0, argmax_val}, 32'h7FFFFF);
      run_stream(1, mk_fill(24'hFFFFFE));
      chk("argmax_tie_idx", {28'b0, argmax_idx}, 32'd0);
      chk("argmax_tie_val", {8'b0, argmax_val}, 32'hFFFFFE);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
